npu_queue_interface: RTL and testbench

Processor-side queue block between the pipeline's NPU instructions and the neural processing unit. It buffers configuration words and input operands from the EX stage toward the NPU, and returns NPU results to the EX stage. It is the source of the config-full, input-full and output-empty flags that the hazard detection unit consumes to raise a full stall.

---
 rtl/npu_queue_interface_pkg.sv | 10 +
 rtl/npu_sync_fifo.sv | 40 ++++
 rtl/npu_queue_interface.sv | 57 +++++
 tb/tb_npu_queue_interface.sv | 102 ++++++++++
 4 files changed

// File: rtl/npu_queue_interface_pkg.sv
// npu_queue_interface_pkg: shared widths, default queue depths and pointer sizing for the NPU queue block.
package npu_queue_interface_pkg;
  localparam int NPU_DATA_WIDTH = 32;
  localparam int NPU_CFG_DEPTH  = 8;
  localparam int NPU_IN_DEPTH   = 8;
  localparam int NPU_OUT_DEPTH  = 8;
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/npu_sync_fifo.sv
// npu_sync_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers.
module npu_sync_fifo
  import npu_queue_interface_pkg::*;
#(
  parameter int DATA_WIDTH = NPU_DATA_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iPush,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iPop,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oFull,
  output logic                  oEmpty
);
  localparam int PW = ptrWidth(DEPTH);
  localparam int AW = PW - 1;
  logic [PW-1:0] wrPtr, rdPtr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic doPush, doPop;
  assign oFull  = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  assign oEmpty = wrPtr == rdPtr;
  assign doPush = iPush & ~oFull;
  assign doPop  = iPop & ~oEmpty;
  assign oData  = mem[rdPtr[AW-1:0]];
  always_ff @(posedge iClk) begin
    if (iReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      wrPtr <= doPush ? wrPtr + PW'(1) : wrPtr;
      rdPtr <= doPop ? rdPtr + PW'(1) : rdPtr;
    end
  end
  // Storage needs no reset: pointers alone decide what is visible.
  always_ff @(posedge iClk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= iData;
  end
endmodule

// File: rtl/npu_queue_interface.sv
// npu_queue_interface: config/input queues toward the NPU and result queue back to EX,
// with hazard flags and a sticky protocol-error bit.
module npu_queue_interface
  import npu_queue_interface_pkg::*;
#(
  parameter int DATA_WIDTH = NPU_DATA_WIDTH,
  parameter int CFG_DEPTH  = NPU_CFG_DEPTH,
  parameter int IN_DEPTH   = NPU_IN_DEPTH,
  parameter int OUT_DEPTH  = NPU_OUT_DEPTH
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iCfgWrite,
  input  logic [DATA_WIDTH-1:0] iCfgData,
  input  logic                  iEnqWrite,
  input  logic [DATA_WIDTH-1:0] iEnqData,
  input  logic                  iDeqRead,
  output logic [DATA_WIDTH-1:0] oDeqData,
  output logic                  oNpuConfigFull,
  output logic                  oNpuInputFull,
  output logic                  oNpuOutputEmpty,
  output logic                  oCfgValid,
  output logic [DATA_WIDTH-1:0] oCfgData,
  input  logic                  iCfgReady,
  output logic                  oInValid,
  output logic [DATA_WIDTH-1:0] oInData,
  input  logic                  iInReady,
  input  logic                  iOutValid,
  input  logic [DATA_WIDTH-1:0] iOutData,
  output logic                  oOutReady,
  output logic                  oError
);
  logic cfgFull, cfgEmpty, inFull, inEmpty, outFull, outEmpty;
  npu_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(CFG_DEPTH)) cfgQ (
    .iClk(iClk), .iReset(iReset), .iPush(iCfgWrite), .iData(iCfgData),
    .iPop(iCfgReady), .oData(oCfgData), .oFull(cfgFull), .oEmpty(cfgEmpty)
  );
  npu_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) inQ (
    .iClk(iClk), .iReset(iReset), .iPush(iEnqWrite), .iData(iEnqData),
    .iPop(iInReady), .oData(oInData), .oFull(inFull), .oEmpty(inEmpty)
  );
  npu_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(OUT_DEPTH)) outQ (
    .iClk(iClk), .iReset(iReset), .iPush(iOutValid), .iData(iOutData),
    .iPop(iDeqRead), .oData(oDeqData), .oFull(outFull), .oEmpty(outEmpty)
  );
  assign oNpuConfigFull  = cfgFull;
  assign oNpuInputFull   = inFull;
  assign oNpuOutputEmpty = outEmpty;
  assign oCfgValid       = ~cfgEmpty;
  assign oInValid        = ~inEmpty;
  assign oOutReady       = ~outFull;
  // Only processor-side misuse is an error; NPU handshakes cannot overflow.
  always_ff @(posedge iClk) begin
    if (iReset) oError <= 1'b0;
    else if ((iCfgWrite & cfgFull) | (iEnqWrite & inFull) | (iDeqRead & outEmpty)) oError <= 1'b1;
  end
endmodule

// File: tb/tb_npu_queue_interface.sv
// tb_npu_queue_interface: directed table-driven bench for the NPU queue block.
module tb_npu_queue_interface;
  logic iClk = 0, iReset, iCfgWrite, iEnqWrite, iDeqRead, iCfgReady, iInReady, iOutValid;
  logic [31:0] iCfgData, iEnqData, iOutData, oDeqData, oCfgData, oInData;
  logic oNpuConfigFull, oNpuInputFull, oNpuOutputEmpty, oCfgValid, oInValid, oOutReady, oError;
  int nCmp = 0, nFail = 0;
  typedef struct {
    logic rs, cw; logic [31:0] cd; logic ew; logic [31:0] ed; logic dr, cr, ir, ov; logic [31:0] od;
    logic [6:0] ef; logic [1:0] ds; logic [31:0] edat;
  } vec_t;
  vec_t tbl [10];

  npu_queue_interface dut (
    .iClk(iClk), .iReset(iReset), .iCfgWrite(iCfgWrite), .iCfgData(iCfgData),
    .iEnqWrite(iEnqWrite), .iEnqData(iEnqData), .iDeqRead(iDeqRead), .oDeqData(oDeqData),
    .oNpuConfigFull(oNpuConfigFull), .oNpuInputFull(oNpuInputFull), .oNpuOutputEmpty(oNpuOutputEmpty),
    .oCfgValid(oCfgValid), .oCfgData(oCfgData), .iCfgReady(iCfgReady),
    .oInValid(oInValid), .oInData(oInData), .iInReady(iInReady),
    .iOutValid(iOutValid), .iOutData(iOutData), .oOutReady(oOutReady), .oError(oError)
  );

  always #5 iClk = ~iClk;

  function automatic vec_t mk(logic rs, logic cw, logic [31:0] cd, logic ew, logic [31:0] ed, logic dr,
                              logic cr, logic ir, logic ov, logic [31:0] od, logic [6:0] ef,
                              logic [1:0] ds, logic [31:0] edat);
    vec_t v;
    v.rs = rs; v.cw = cw; v.cd = cd; v.ew = ew; v.ed = ed; v.dr = dr; v.cr = cr; v.ir = ir;
    v.ov = ov; v.od = od; v.ef = ef; v.ds = ds; v.edat = edat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Flags packed as {cfgFull, inFull, outEmpty, cfgValid, inValid, outReady, error}.
  task automatic apply(input vec_t v, input string nm);
    logic [31:0] d;
    @(negedge iClk);
    iReset = v.rs; iCfgWrite = v.cw; iCfgData = v.cd; iEnqWrite = v.ew; iEnqData = v.ed;
    iDeqRead = v.dr; iCfgReady = v.cr; iInReady = v.ir; iOutValid = v.ov; iOutData = v.od;
    @(posedge iClk);
    #1;
    chk({nm, " flags"}, {25'd0, oNpuConfigFull, oNpuInputFull, oNpuOutputEmpty, oCfgValid, oInValid,
        oOutReady, oError}, {25'd0, v.ef});
    d = v.ds == 2'd1 ? oCfgData : v.ds == 2'd2 ? oInData : oDeqData;
    if (v.ds != 2'd0) chk({nm, " data"}, d, v.edat);
  endtask

  initial begin
    tbl[0] = mk(0, 0, 0,     0, 0,     0, 0, 0, 0, 0,     7'b0010010, 0, 0);
    tbl[1] = mk(0, 1, 'hC0,  0, 0,     0, 0, 0, 0, 0,     7'b0011010, 1, 'hC0);
    tbl[2] = mk(0, 1, 'hC1,  0, 0,     0, 1, 0, 0, 0,     7'b0011010, 1, 'hC1);
    tbl[3] = mk(0, 1, 'hC2,  0, 0,     0, 1, 0, 0, 0,     7'b0011010, 1, 'hC2);
    tbl[4] = mk(0, 0, 0,     0, 0,     0, 1, 0, 0, 0,     7'b0010010, 0, 0);
    tbl[5] = mk(0, 0, 0,     1, 'hE0,  0, 0, 0, 0, 0,     7'b0010110, 2, 'hE0);
    tbl[6] = mk(0, 0, 0,     0, 0,     0, 0, 1, 0, 0,     7'b0010010, 0, 0);
    tbl[7] = mk(0, 0, 0,     0, 0,     0, 0, 0, 1, 'hA5,  7'b0000010, 3, 'hA5);
    tbl[8] = mk(0, 0, 0,     0, 0,     1, 0, 0, 0, 0,     7'b0010010, 0, 0);
    tbl[9] = mk(0, 0, 0,     0, 0,     1, 0, 0, 0, 0,     7'b0010011, 0, 0);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0010010, 0, 0), "reset");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0010010, 0, 0), "reset2");
    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("tbl%0d", i));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0010010, 0, 0), "reset3");
    // Input queue fill, overflow drop, then ordered drain.
    for (int i = 0; i < 8; i++)
      apply(mk(0, 0, 0, 1, 32'h10 + i, 0, 0, 0, 0, 0, i == 7 ? 7'b0110110 : 7'b0010110, 2, 'h10),
            $sformatf("inFill%0d", i));
    apply(mk(0, 0, 0, 1, 'hFF, 0, 0, 0, 0, 0, 7'b0110111, 2, 'h10), "inOverflow");
    for (int k = 1; k <= 8; k++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, k == 8 ? 7'b0010011 : 7'b0010111, k == 8 ? 2'd0 : 2'd2,
            32'h10 + k), $sformatf("inDrain%0d", k));
    // Config streaming with ready held high: occupancy stays at one.
    for (int i = 0; i < 10; i++)
      apply(mk(0, 1, 32'h200 + i, 0, 0, 0, 1, 0, 0, 0, 7'b0011011, 1, 32'h200 + i), $sformatf("cfgStream%0d", i));
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7'b0010011, 0, 0), "cfgStreamEnd");
    // Output queue fill, then simultaneous dequeue and NPU push while full.
    for (int i = 0; i < 8; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB0 + i, i == 7 ? 7'b0000001 : 7'b0000011, 3, 'hB0),
            $sformatf("outFill%0d", i));
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 'hCC, 7'b0000011, 3, 'hB1), "outPopPushFull");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'hCC, 7'b0000001, 3, 'hB1), "outHeldPush");
    for (int k = 1; k <= 8; k++)
      apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, k == 8 ? 7'b0010011 : 7'b0000011, k == 8 ? 2'd0 : 2'd3,
            k == 7 ? 32'hCC : 32'hB1 + k), $sformatf("outDrain%0d", k));
    // Mid-operation reset flushes half-full queues.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0010010, 0, 0), "reset4");
    for (int i = 0; i < 4; i++)
      apply(mk(0, 1, 32'h30 + i, 1, 32'h40 + i, 0, 0, 0, 1, 32'h50 + i, 7'b0001110, 3, 'h50),
            $sformatf("halfFill%0d", i));
    apply(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7'b0010010, 0, 0), "flushReset");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7'b0010010, 0, 0), "flushIdle");
    apply(mk(0, 1, 'h55, 0, 0, 0, 0, 0, 0, 0, 7'b0011010, 1, 'h55), "postFlushCfg");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
